// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop recovery with a valid/ready
// output register carrying parity, framing and overrun status.
module uart_rx_core #(
    parameter int DATA_BITS     = 8,
    parameter int SAMPLING_RATE = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick_rx_i,
    input  logic                 rx_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int CNT_W = $clog2(SAMPLING_RATE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLING_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLING_RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   par_en_reg, par_en_next;
    logic                   par_odd_reg, par_odd_next;
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   done_reg, done_next;

    logic [DATA_BITS-1:0]   data_reg;
    logic                   valid_reg;
    logic                   perr_out_reg;
    logic                   ferr_out_reg;
    logic                   overrun_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            par_en_reg  <= par_en_next;
            par_odd_reg <= par_odd_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        par_en_next  = par_en_reg;
        par_odd_next = par_odd_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        done_next    = 1'b0;
        if (tick_rx_i) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next   = START;
                        cnt_next     = '0;
                        par_en_next  = parity_en_i;
                        par_odd_next = parity_odd_i;
                        perr_next    = 1'b0;
                    end
                end
                START: begin
                    // A line that is high again at mid start bit was only a glitch
                    if (cnt_reg == CNT_HALF) begin
                        cnt_next     = '0;
                        bit_idx_next = '0;
                        state_next   = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next     = '0;
                        shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                        if (bit_idx_reg == IDX_LAST) begin
                            state_next = par_en_reg ? PARITY : STOP;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        perr_next  = rx_s ^ (^shift_reg) ^ par_odd_reg;
                        state_next = STOP;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Back to IDLE at mid stop bit so an early next start edge is caught
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (valid_reg && ready_i) begin
                valid_reg <= 1'b0;
            end
            if (done_reg) begin
                if (!valid_reg || ready_i) begin
                    data_reg     <= shift_reg;
                    perr_out_reg <= perr_reg;
                    ferr_out_reg <= ferr_reg;
                    valid_reg    <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign parity_err_o = perr_out_reg;
    assign frame_err_o  = ferr_out_reg;
    assign overrun_o    = overrun_reg;
    assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized scoreboard bench for uart_rx_core: frames are serialized at 16 ticks
// per bit (one tick every two clocks) and compared against a parity/stop model.
module tb_uart_rx_core;
    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_rx_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       parity_en_i = 1'b0;
    logic       parity_odd_i = 1'b0;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int     checks = 0;
    int     failures = 0;
    int     ovr_seen = 0;
    int     ovr_exp = 0;

    uart_rx_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_rx_i    (tick_rx_i),
        .rx_i         (rx_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            tick_rx_i = ~tick_rx_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        step(n);
    endtask

    // Parity error = total ones over data+parity bit disagree with the chosen sense
    function automatic logic model_perr(input logic [7:0] d, input logic pen,
                                        input logic podd, input logic pbit);
        int ones;
        if (!pen) return 1'b0;
        ones = $countones(d) + int'(pbit);
        return (ones % 2) != (podd ? 1 : 0);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic pbit, input logic stop_ok);
        parity_en_i  = pen;
        parity_odd_i = podd;
        drive_bit(1'b0, BIT_CLKS);
        parity_en_i  = 1'($urandom_range(0, 1));
        parity_odd_i = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        if (pen) drive_bit(pbit, BIT_CLKS);
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            // Low only through the mid-bit sample, so no false start follows
            drive_bit(1'b0, 18);
            drive_bit(1'b1, BIT_CLKS - 18);
        end
    endtask

    // mode 0: delivered, 1: dropped with overrun, 2: wiped by reset
    task automatic issue(input logic [7:0] d, input logic pen, input logic podd,
                         input logic pbit, input logic stop_ok, input int mode);
        frame_t f;
        f.data = d;
        f.perr = model_perr(d, pen, podd, pbit);
        f.ferr = ~stop_ok;
        if (mode == 0) exp_q.push_back(f);
        else if (mode == 1) ovr_exp++;
        send_frame(d, pen, podd, pbit, stop_ok);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (overrun_o) ovr_seen++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%0h required=none", data_o);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(mon_f.data));
                    check("parity_err", 32'(parity_err_o), 32'(mon_f.perr));
                    check("frame_err", 32'(frame_err_o), 32'(mon_f.ferr));
                    $display("frame data=%02h perr=%0d ferr=%0d", data_o, parity_err_o, frame_err_o);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pen, podd, pbad, sok, pbit;
        bit         found;

        step(3);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_perr", 32'(parity_err_o), 0);
        check("rst_ferr", 32'(frame_err_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        reset_n = 1'b1;
        step(5);

        issue(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(4);
        check("busy_after_55", 32'(busy_o), 0);
        issue(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        issue(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 0);

        // Start-bit glitch of four ticks
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 16);
        check("busy_after_glitch", 32'(busy_o), 0);
        issue(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        issue(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbad = ($urandom_range(0, 3) == 0);
            sok  = ($urandom_range(0, 4) != 0);
            pbit = ((($countones(d) % 2) == 1) ^ podd) ^ pbad;
            issue(d, pen, podd, pbit, sok, 0);
            step($urandom_range(0, 40));
        end
        step(6);

        // Overrun, then accept and reload on the same clock
        ready_i = 1'b0;
        issue(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        issue(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        fork
            issue(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            begin
                found = 1'b0;
                step(2 * BIT_CLKS);
                for (int i = 0; i < 12 * BIT_CLKS; i++) begin
                    if (!busy_o) begin
                        found = 1'b1;
                        break;
                    end
                    step(1);
                end
                check("stop_seen_33", 32'(found), 1);
                ready_i = 1'b1;
                @(negedge clk);
                check("held_valid_11", 32'(valid_o), 1);
                check("held_data_11", 32'(data_o), 32'h11);
                @(negedge clk);
                check("reload_valid_33", 32'(valid_o), 1);
                check("reload_data_33", 32'(data_o), 32'h33);
            end
        join
        step(10);
        check("valid_drop_after_33", 32'(valid_o), 0);

        // Async reset mid data bit 4 with a frame parked in the output
        ready_i = 1'b0;
        issue(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        step(4);
        check("parked_valid", 32'(valid_o), 1);
        check("parked_data", 32'(data_o), 32'h5A);
        check("parked_perr", 32'(parity_err_o), 1);
        check("parked_ferr", 32'(frame_err_o), 1);
        parity_en_i = 1'b0;
        d = 8'hC7;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
        rx_i = d[4];
        step(16);
        check("busy_before_reset", 32'(busy_o), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_data", 32'(data_o), 0);
        check("mid_rst_perr", 32'(parity_err_o), 0);
        check("mid_rst_ferr", 32'(frame_err_o), 0);
        check("mid_rst_overrun", 32'(overrun_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        step(3);
        rx_i    = 1'b1;
        reset_n = 1'b1;
        ready_i = 1'b1;
        step(5);
        issue(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) step(1);
        step(4);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        check("final_busy", 32'(busy_o), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
